// File: rtl/axis_demux_pkg.sv
// Shared types for the 1:2 AXI-Stream packet demultiplexer.
package axis_demux_pkg;

  typedef enum logic {DEST_M2 = 1'b0, DEST_M1 = 1'b1} dest_e;
  typedef enum logic {ST_SOP = 1'b0, ST_MID = 1'b1} pkt_st_e;

  // Sideband bits carried with each beat: last and dest.
  localparam int unsigned META_W = 2;

  function automatic dest_e sel_to_dest(input logic sel);
    return sel ? DEST_M1 : DEST_M2;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry register slice (OUT + SKID) with registered input ready and
// registered output; SKID always drains ahead of new input beats.
module axis_skid_reg #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept;
  logic         out_free;

  always_comb begin
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    accept       = in_valid_i && in_ready_q;
    out_free     = !out_valid_q || out_ready_i;

    if (out_free) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = in_data_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    // A beat that could not go straight to OUT parks in SKID.
    if (accept && !(out_free && !skid_valid_q)) begin
      skid_data_d  = in_data_i;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
      out_data_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      out_data_q   <= out_data_d;
    end
  end

  // SKID contents are only meaningful while skid_valid_q is set.
  always_ff @(posedge clk) begin
    skid_data_q <= skid_data_d;
  end

  assign in_ready_o  = in_ready_q;
  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/axis_demux_1_2.sv
// AXI-Stream 1:2 packet demux: destination chosen from sel at the first beat
// of a packet and held until tlast; registered skid slice on the datapath.
module axis_demux_1_2
  import axis_demux_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel,
  input  logic [DW-1:0] s_tdata,
  input  logic          s_tvalid,
  input  logic          s_tlast,
  output logic          s_tready,
  output logic [DW-1:0] m1_tdata,
  output logic          m1_tvalid,
  output logic          m1_tlast,
  input  logic          m1_tready,
  output logic [DW-1:0] m2_tdata,
  output logic          m2_tvalid,
  output logic          m2_tlast,
  input  logic          m2_tready
);

  localparam int unsigned PW = DW + META_W;

  pkt_st_e       in_pkt_q, in_pkt_d;
  dest_e         lock_dest_q, lock_dest_d;
  dest_e         beat_dest;
  dest_e         out_dest;
  logic          accept;
  logic          s_ready;
  logic [PW-1:0] in_payload;
  logic [PW-1:0] out_payload;
  logic          out_valid;
  logic          out_ready_sel;
  logic          out_last;
  logic [DW-1:0] out_data;

  assign accept = s_tvalid && s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_pkt_q    <= ST_SOP;
      lock_dest_q <= DEST_M2;
    end else begin
      in_pkt_q    <= in_pkt_d;
      lock_dest_q <= lock_dest_d;
    end
  end

  always_comb begin
    in_pkt_d    = in_pkt_q;
    lock_dest_d = lock_dest_q;
    beat_dest   = lock_dest_q;
    case (in_pkt_q)
      ST_SOP: begin
        beat_dest = sel_to_dest(sel);
        if (accept) begin
          lock_dest_d = beat_dest;
          if (!s_tlast) in_pkt_d = ST_MID;
        end
      end
      ST_MID: begin
        if (accept && s_tlast) in_pkt_d = ST_SOP;
      end
      default: in_pkt_d = ST_SOP;
    endcase
  end

  assign in_payload = {logic'(beat_dest), s_tlast, s_tdata};

  axis_skid_reg #(
    .W(PW)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (in_payload),
    .in_valid_i (s_tvalid),
    .in_ready_o (s_ready),
    .out_data_o (out_payload),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready_sel)
  );

  // Only the port the head beat is routed to can drain it.
  assign out_dest      = dest_e'(out_payload[PW-1]);
  assign out_last      = out_payload[DW];
  assign out_data      = out_payload[DW-1:0];
  assign out_ready_sel = (out_dest == DEST_M1) ? m1_tready : m2_tready;

  assign s_tready  = s_ready;
  assign m1_tvalid = out_valid && (out_dest == DEST_M1);
  assign m2_tvalid = out_valid && (out_dest == DEST_M2);
  assign m1_tdata  = out_data;
  assign m2_tdata  = out_data;
  assign m1_tlast  = out_last;
  assign m2_tlast  = out_last;

endmodule

// File: tb/tb_axis_demux_1_2.sv
// Bench for axis_demux_1_2: directed scenarios plus random traffic, checked
// against a queue-based model of accepted-but-undelivered beats.
module tb_axis_demux_1_2;

  typedef struct {
    logic       port;  // 1 = m1, 0 = m2
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic       clk;
  logic       rst;
  logic       sel;
  logic [7:0] s_tdata;
  logic       s_tvalid;
  logic       s_tlast;
  logic       s_tready;
  logic [7:0] m1_tdata;
  logic       m1_tvalid;
  logic       m1_tlast;
  logic       m1_tready;
  logic [7:0] m2_tdata;
  logic       m2_tvalid;
  logic       m2_tlast;
  logic       m2_tready;

  int checks = 0;
  int errors = 0;

  beat_t q[$];
  logic  mdl_mid = 1'b0;
  logic  mdl_port = 1'b0;
  logic  last_acc = 1'b0;
  logic  hold1 = 1'b0, hold2 = 1'b0;
  logic [7:0] hold1_data = 8'h0, hold2_data = 8'h0;
  int    rst_edges = 0;
  logic  armed = 1'b0;
  int    m1_cnt = 0, m2_cnt = 0, acc_cnt = 0;

  axis_demux_1_2 #(.DW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .m1_tdata (m1_tdata),
    .m1_tvalid(m1_tvalid),
    .m1_tlast (m1_tlast),
    .m1_tready(m1_tready),
    .m2_tdata (m2_tdata),
    .m2_tvalid(m2_tvalid),
    .m2_tlast (m2_tlast),
    .m2_tready(m2_tready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    int    n;
    beat_t b;
    logic  ev1, ev2;
    if (rst || rst_edges > 0) begin
      if (rst_edges > 0) begin
        chk("rst_s_tready", 32'(s_tready), 32'(0));
        chk("rst_m1_tvalid", 32'(m1_tvalid), 32'(0));
        chk("rst_m2_tvalid", 32'(m2_tvalid), 32'(0));
        chk("rst_tdata", 32'({m1_tdata, m2_tdata}), 32'(0));
        chk("rst_tlast", 32'({m1_tlast, m2_tlast}), 32'(0));
      end
      q.delete();
      mdl_mid  = 1'b0;
      hold1    = 1'b0;
      hold2    = 1'b0;
      last_acc = 1'b0;
      return;
    end
    if (!armed) return;

    n   = q.size();
    ev1 = (n > 0) && q[0].port;
    ev2 = (n > 0) && !q[0].port;
    chk("s_tready", 32'(s_tready), 32'(n < 2));
    chk("m1_tvalid", 32'(m1_tvalid), 32'(ev1));
    chk("m2_tvalid", 32'(m2_tvalid), 32'(ev2));
    if (n > 0) begin
      chk("m1_tdata", 32'(m1_tdata), 32'(q[0].data));
      chk("m2_tdata", 32'(m2_tdata), 32'(q[0].data));
      chk("m1_tlast", 32'(m1_tlast), 32'(q[0].last));
      chk("m2_tlast", 32'(m2_tlast), 32'(q[0].last));
    end
    if (hold1) chk("m1_stable", 32'({m1_tvalid, m1_tdata}), 32'({1'b1, hold1_data}));
    if (hold2) chk("m2_stable", 32'({m2_tvalid, m2_tdata}), 32'({1'b1, hold2_data}));

    if (m1_tvalid && m1_tready) begin
      m1_cnt++;
      if (q.size() > 0) void'(q.pop_front());
    end
    if (m2_tvalid && m2_tready) begin
      m2_cnt++;
      if (q.size() > 0) void'(q.pop_front());
    end
    hold1      = m1_tvalid && !m1_tready;
    hold2      = m2_tvalid && !m2_tready;
    hold1_data = m1_tdata;
    hold2_data = m2_tdata;

    // Destination comes from sel on a packet's first beat, then sticks.
    last_acc = s_tvalid && s_tready;
    if (last_acc) begin
      acc_cnt++;
      if (!mdl_mid) mdl_port = sel;
      b.port = mdl_port;
      b.data = s_tdata;
      b.last = s_tlast;
      q.push_back(b);
      mdl_mid = !s_tlast;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    if (rst) begin
      rst_edges++;
      armed = 1'b1;
    end else begin
      rst_edges = 0;
    end
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic s, output int cyc);
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    sel      = s;
    cyc      = 0;
    do begin
      tick();
      cyc++;
    end while (!last_acc && cyc < 50);
    s_tvalid = 1'b0;
  endtask

  initial begin
    int cyc, idx, base1, base2, base_acc;
    rst = 1'b1; sel = 1'b0; s_tdata = 8'h0; s_tvalid = 1'b1; s_tlast = 1'b0;
    m1_tready = 1'b1; m2_tready = 1'b1;

    // Reset held three cycles with s_tvalid asserted.
    repeat (3) tick();
    rst = 1'b0;
    s_tvalid = 1'b0;
    tick();
    tick();
    chk("post_rst_s_tready", 32'(s_tready), 32'(1));

    // Packet lock: sel toggles mid-packet, everything must land on m1.
    base1 = m1_cnt; base2 = m2_cnt;
    for (int i = 0; i < 4; i++) begin
      send(8'h11 + 8'(i), (i == 3), ((i % 2) == 0), cyc);
      chk("lock_thru", 32'(cyc), 32'(1));
    end
    repeat (2) tick();
    chk("lock_m1_cnt", 32'(m1_cnt - base1), 32'(4));
    chk("lock_m2_cnt", 32'(m2_cnt - base2), 32'(0));

    // Alternating single-beat packets back-to-back.
    base1 = m1_cnt; base2 = m2_cnt;
    send(8'hA0, 1'b1, 1'b0, cyc);
    chk("alt_thru0", 32'(cyc), 32'(1));
    send(8'hA1, 1'b1, 1'b1, cyc);
    chk("alt_thru1", 32'(cyc), 32'(1));
    send(8'hA2, 1'b1, 1'b0, cyc);
    chk("alt_thru2", 32'(cyc), 32'(1));
    repeat (2) tick();
    chk("alt_m1_cnt", 32'(m1_cnt - base1), 32'(1));
    chk("alt_m2_cnt", 32'(m2_cnt - base2), 32'(2));

    // Backpressure: m2_tready low for five cycles mid-stream.
    base2 = m2_cnt;
    sel = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 100) begin
      s_tvalid  = 1'b1;
      s_tdata   = 8'(idx + 1);
      s_tlast   = (idx == 7);
      m2_tready = !(cyc >= 3 && cyc < 8);
      tick();
      if (last_acc) idx++;
      cyc++;
    end
    s_tvalid  = 1'b0;
    m2_tready = 1'b1;
    chk("bp_all_accepted", 32'(idx), 32'(8));
    repeat (3) tick();
    chk("bp_m2_cnt", 32'(m2_cnt - base2), 32'(8));

    // Unselected port stalled: m2 traffic must run at full rate.
    m1_tready = 1'b0;
    base2 = m2_cnt;
    for (int i = 0; i < 4; i++) begin
      send(8'h51 + 8'(i), (i == 3), 1'b0, cyc);
      chk("unsel_thru", 32'(cyc), 32'(1));
    end
    repeat (2) tick();
    chk("unsel_m2_cnt", 32'(m2_cnt - base2), 32'(4));

    // Reset mid-packet with SKID full, then a fresh packet to m2.
    send(8'h31, 1'b0, 1'b1, cyc);
    send(8'h32, 1'b0, 1'b1, cyc);
    tick();
    chk("mid_skid_full", 32'(s_tready), 32'(0));
    rst = 1'b1;
    s_tvalid = 1'b1;
    s_tdata = 8'h33;
    repeat (2) tick();
    rst = 1'b0;
    s_tvalid = 1'b0;
    m1_tready = 1'b1;
    tick();
    base1 = m1_cnt; base2 = m2_cnt;
    send(8'h41, 1'b0, 1'b0, cyc);
    send(8'h42, 1'b1, 1'b1, cyc);
    repeat (2) tick();
    chk("rstmid_m1_cnt", 32'(m1_cnt - base1), 32'(0));
    chk("rstmid_m2_cnt", 32'(m2_cnt - base2), 32'(2));

    // Random traffic.
    base_acc = acc_cnt;
    for (int i = 0; i < 1500; i++) begin
      sel       = 1'($urandom_range(0, 1));
      s_tvalid  = ($urandom_range(0, 3) != 0);
      s_tlast   = ($urandom_range(0, 9) < 3);
      s_tdata   = 8'($urandom);
      m1_tready = ($urandom_range(0, 9) < 7);
      m2_tready = ($urandom_range(0, 9) < 7);
      tick();
    end
    s_tvalid  = 1'b0;
    m1_tready = 1'b1;
    m2_tready = 1'b1;
    repeat (4) tick();
    chk("rand_drained", 32'(q.size()), 32'(0));
    chk("rand_some_traffic", 32'(acc_cnt - base_acc > 500), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
